compressor: RTL and testbench

COMPRESSOR -- requirements
Module: compressor

---
 rtl/compressor_pkg.sv | 16 +
 rtl/compressor_arith_lane_calc.sv | 40 ++++
 rtl/compressor.sv | 178 +++++++++++++++++
 tb/tb_compressor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_pkg.sv
// Shared types and constants for the multi-lane binary arithmetic compressor.
package compressor_pkg;
    localparam int PROB_BITS = 12;
    localparam int LANES = 8;
    localparam logic [PROB_BITS-1:0] PROB_INIT = 12'd2048;
    localparam logic [31:0] X2_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FETCH,
        ST_CODE,
        ST_EMIT,
        ST_FLUSH
    } state_t;
endpackage

// File: rtl/compressor_arith_lane_calc.sv
// One binary arithmetic-coding step: interval split at p/4096 plus probability adaptation.
module arith_lane_calc
    import compressor_pkg::*;
#(
    parameter int RATE = 4
) (
    input  logic [31:0]          x1,
    input  logic [31:0]          x2,
    input  logic [PROB_BITS-1:0] p,
    input  logic                 b,
    output logic [31:0]          x1_next,
    output logic [31:0]          x2_next,
    output logic [PROB_BITS-1:0] p_next
);
    logic [31:0] range;
    logic [31:0] hi_part;
    logic [31:0] lo_part;
    logic [31:0] xmid;
    logic [12:0] p_gap;
    logic [12:0] gap_step;

    always_comb begin
        range    = x2 - x1;
        // Split the multiply so the product never overflows 32 bits.
        hi_part  = (range >> PROB_BITS) * {20'd0, p};
        lo_part  = ((range & 32'h0000_0FFF) * {20'd0, p}) >> PROB_BITS;
        xmid     = x1 + hi_part + lo_part;
        p_gap    = 13'h1000 - {1'b0, p};
        gap_step = p_gap >> RATE;
        if (b) begin
            x1_next = x1;
            x2_next = xmid;
            p_next  = p + gap_step[PROB_BITS-1:0];
        end else begin
            x1_next = xmid + 32'd1;
            x2_next = x2;
            p_next  = p - (p >> RATE);
        end
    end
endmodule

// File: rtl/compressor.sv
// Eight-lane bitwise arithmetic coder: lane k codes bit k of every byte with a
// shared context-indexed probability table, emitting settled top bytes per lane.
module compressor
    import compressor_pkg::*;
#(
    parameter int RATE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       init_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_idx,
    output logic [7:0] out_byte,
    output logic       out_last
);
    state_t                 state;
    logic [7:0]             clr_cnt;
    logic [7:0]             byte_q;
    logic                   last_q;
    logic [7:0]             ctx;
    logic [2:0]             k;
    logic [2:0]             lane;
    logic [31:0]            x1_q [LANES];
    logic [31:0]            x2_q [LANES];

    logic [PROB_BITS-1:0]   prob_ram [256];
    logic [PROB_BITS-1:0]   rd_data;
    logic                   ram_we;
    logic [7:0]             ram_addr;
    logic [PROB_BITS-1:0]   ram_wdata;

    logic [31:0]            x1_next;
    logic [31:0]            x2_next;
    logic [PROB_BITS-1:0]   p_next;
    logic                   cur_bit;
    logic                   emit_match;

    assign cur_bit    = byte_q[k];
    assign emit_match = (x1_q[k][31:24] == x2_q[k][31:24]);

    arith_lane_calc #(.RATE(RATE)) u_calc (
        .x1      (x1_q[k]),
        .x2      (x2_q[k]),
        .p       (rd_data),
        .b       (cur_bit),
        .x1_next (x1_next),
        .x2_next (x2_next),
        .p_next  (p_next)
    );

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ctx;
        ram_wdata = p_next;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_wdata = PROB_INIT;
        end else if (state == ST_CODE) begin
            ram_we    = 1'b1;
        end
    end

    // Read issued in FETCH lands in rd_data for CODE.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            prob_ram[ram_addr] <= ram_wdata;
        end
        rd_data <= prob_ram[ctx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            clr_cnt   <= 8'd0;
            byte_q    <= 8'd0;
            last_q    <= 1'b0;
            ctx       <= 8'd0;
            k         <= 3'd0;
            lane      <= 3'd0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= 8'd0;
            out_byte  <= 8'd0;
            out_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                x1_q[i] <= 32'd0;
                x2_q[i] <= X2_INIT;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 8'd1;
                    for (int i = 0; i < LANES; i++) begin
                        x1_q[i] <= 32'd0;
                        x2_q[i] <= X2_INIT;
                    end
                    if (clr_cnt == 8'd255) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        byte_q   <= in_byte;
                        last_q   <= in_last;
                        ctx      <= 8'd1;
                        k        <= 3'd7;
                        in_ready <= 1'b0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_CODE;
                end
                ST_CODE: begin
                    x1_q[k] <= x1_next;
                    x2_q[k] <= x2_next;
                    ctx     <= {ctx[6:0], cur_bit};
                    state   <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            x1_q[k]   <= x1_q[k] << 8;
                            x2_q[k]   <= {x2_q[k][23:0], 8'hFF};
                        end
                    end else if (emit_match) begin
                        out_valid <= 1'b1;
                        out_byte  <= x2_q[k][31:24];
                        out_idx   <= {5'd0, k};
                        out_last  <= 1'b0;
                    end else if (k != 3'd0) begin
                        k     <= k - 3'd1;
                        state <= ST_FETCH;
                    end else if (!last_q) begin
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        lane  <= 3'd0;
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (lane == 3'd7) begin
                                clr_cnt   <= 8'd0;
                                init_done <= 1'b0;
                                state     <= ST_INIT;
                            end else begin
                                lane <= lane + 3'd1;
                            end
                        end
                    end else begin
                        out_valid <= 1'b1;
                        out_byte  <= x1_q[lane][31:24];
                        out_idx   <= {5'd0, lane};
                        out_last  <= (lane == 3'd7);
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_compressor.sv
// Randomized bench for compressor: reference coder model with expected-output queue.
module tb_compressor;
    localparam int RATE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'd0;
    logic       in_last = 1'b0;
    logic       init_done;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_idx;
    logic [7:0] out_byte;
    logic       out_last;

    int n_checks = 0;
    int n_fail = 0;

    // Expected/observed words are {last, idx, byte}.
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    int unsigned m_lo [8];
    int unsigned m_hi [8];
    int unsigned m_prob [256];

    bit rand_ready = 1'b0;
    bit arm_stall = 1'b0;
    int stall_left = 0;
    bit prev_hold = 1'b0;
    logic [16:0] prev_data = '0;

    compressor #(.RATE(RATE)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .init_done (init_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic void model_clear();
        for (int i = 0; i < 256; i++) m_prob[i] = 2048;
        for (int i = 0; i < 8; i++) begin
            m_lo[i] = 0;
            m_hi[i] = 32'hFFFF_FFFF;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] d, input bit last);
        int unsigned ctx = 1;
        for (int k = 7; k >= 0; k--) begin
            int unsigned r, p, mid;
            bit b = d[k];
            p = m_prob[ctx];
            r = m_hi[k] - m_lo[k];
            mid = m_lo[k] + (r / 4096) * p + ((r % 4096) * p) / 4096;
            if (b) m_hi[k] = mid;
            else   m_lo[k] = mid + 1;
            if (b) m_prob[ctx] = p + (4096 - p) / (1 << RATE);
            else   m_prob[ctx] = p - p / (1 << RATE);
            ctx = (ctx * 2 + b) % 256;
            while ((m_lo[k] >> 24) == (m_hi[k] >> 24)) begin
                exp_q.push_back({1'b0, 8'(k), 8'(m_hi[k] >> 24)});
                m_lo[k] = m_lo[k] << 8;
                m_hi[k] = (m_hi[k] << 8) | 32'hFF;
            end
        end
        if (last) begin
            for (int i = 0; i < 8; i++)
                exp_q.push_back({(i == 7), 8'(i), 8'(m_lo[i] >> 24)});
            model_clear();
        end
    endfunction

    // output sink + scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            stall_left = 0;
            out_ready = 1'b1;
        end else begin
            if (arm_stall && out_valid) begin
                arm_stall = 1'b0;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                check("stall_in_ready", in_ready, 0);
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_last, out_idx, out_byte}, prev_data);
            end
            if (out_valid) check("busy_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                obs_q.push_back({out_last, out_idx, out_byte});
                check("exp_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_word", {out_last, out_idx, out_byte}, exp_q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev_data = {out_last, out_idx, out_byte};
        end
    end

    // driver tasks
    task automatic init_time(input string tag);
        int n = 0;
        in_valid = 1'b1;
        in_byte = 8'hAA;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 100) check("init_in_ready_low", in_ready, 0);
            if (n == 200) in_valid = 1'b0;
        end while (!init_done && n < 400);
        in_valid = 1'b0;
        check(tag, n, 256);
        check("init_in_ready", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", in_ready, 1);
        in_valid = 1'b1;
        in_byte = d;
        in_last = last;
        model_byte(d, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    task automatic check_flush_pattern(input string tag, input logic [7:0] b);
        check({tag, "_count"}, obs_q.size(), 8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check(tag, obs_q[i], {(i == 7), 8'(i), b});
        obs_q.delete();
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_byte", out_byte, 0);
        rst_n = 1'b1;
        init_time("init_cycles");

        // all-zero byte: every lane flushes 0x80
        obs_q.delete();
        send_byte(8'h00, 1'b1);
        wait_done();
        check_flush_pattern("zero_flush", 8'h80);
        check("reinit_done", init_done, 1);

        // all-one byte: every lane flushes 0x00
        send_byte(8'hFF, 1'b1);
        wait_done();
        check_flush_pattern("ones_flush", 8'h00);

        // table adaptation and stalled flush
        send_byte(8'h00, 1'b0);
        wait_done();
        check("table1_first", u_dut.prob_ram[1], 1920);
        arm_stall = 1'b1;
        send_byte(8'h00, 1'b1);
        begin
            int t = 0;
            while (stall_left == 0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
        check("stall_seen", stall_left != 0, 1);
        check("table1_second", u_dut.prob_ram[1], 1800);
        wait_done();
        obs_q.delete();

        // reset mid-byte
        send_byte(8'h00, 1'b1);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_out_idx", out_idx, 0);
        check("midrst_out_byte", out_byte, 0);
        exp_q.delete();
        obs_q.delete();
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        init_time("reinit_cycles");
        send_byte(8'h00, 1'b1);
        wait_done();
        check_flush_pattern("after_rst_flush", 8'h80);

        // random streams with random backpressure
        rand_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            int len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                logic [7:0] d;
                case ($urandom_range(0, 2))
                    0: d = 8'h00;
                    1: d = 8'hFF;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                send_byte(d, i == len - 1);
            end
            wait_done();
        end
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
